sfu_row_reduce: RTL and testbench
=================================

// Module: sfu_row_reduce
// PURPOSE
// Streaming row-reduction engine for the SFU datapath. Consumes a row of LANES-wide signed
// integer beats and produces one of: the row max, the row sum, or the row replayed with the
// max subtracted (the fixed-point softmax pre-step). Unlike the previous SFU, its output side
// has full valid/ready backpressure, and a row buffer replays the row so input is read once.
// PARAMETERS
// LANES     16                      elements per beat
// DATA_W    32                      signed element width (two's complement)
// MAX_BEATS 32                      row buffer depth, in beats
// BEAT_W    $clog2(MAX_BEATS+1)     width of the beat-count field
// PORTS
// clk_i        in   1             clock
// rst_ni       in   1             asynchronous active-low reset
// cfg_mode_i   in   2             0=MAX, 1=SUM, 2=SUB_MAX, 3=reserved
// cfg_beats_i  in   BEAT_W        row length in beats, 1..MAX_BEATS
// start_i      in   1             start pulse; cfg_* sampled in the same cycle
// busy_o       out  1             state != IDLE
// done_o       out  1             1-cycle pulse, operation complete
// err_o        out  1             1-cycle pulse, start rejected
// in_valid_i   in   1             input beat valid
// in_ready_o   out  1             input beat accepted when valid&ready
// in_data_i    in   LANES*DATA_W  lane k = bits [k*DATA_W +: DATA_W]
// out_valid_o  out  1             output beat valid
// out_ready_i  in   1             downstream ready
// out_data_o   out  LANES*DATA_W  output beat
// BEHAVIOUR
// - Reset: state=IDLE; busy_o, done_o, err_o, in_ready_o, out_valid_o = 0; out_data_o = 0.
//   Counters and accumulators are cleared; row buffer contents are not reset.
// - Reset is honoured mid-operation: the block aborts to IDLE, and out_valid_o/in_ready_o fall
//   asynchronously.
// - States:
//   - IDLE: on start_i with mode<=2 and 1<=beats<=MAX_BEATS, latch cfg, clear the beat
//     counter, set max_acc = most negative value and sum_acc = 0, go to LOAD. Otherwise start_i
//     pulses err_o the next cycle and the block stays in IDLE.
//   - Any state but IDLE: start_i is ignored.
//   - LOAD: in_ready_o=1 (combinational from state). Each handshake updates:
//     - max_acc = max(max_acc, max over lanes);
//     - sum_acc = sum_acc + sum over lanes, wrapping mod 2^DATA_W;
//     - in SUB_MAX, buf[cnt] = beat.
//     Idle cycles (in_valid_i=0) are allowed. When the handshake on beat beats-1 completes,
//     go to RESULT (MAX/SUM) or REPLAY (SUB_MAX).
//   - RESULT: out_valid_o=1. Lane0 = max_acc (MAX) or sum_acc (SUM); other lanes = 0. Data is
//     held stable until out_ready_i. On handshake, go to IDLE.
//   - REPLAY: rd_ptr starts at 0. out_valid_o=1; lane k = buf[rd_ptr].k - max_acc, wrapping.
//     Data is stable while stalled; rd_ptr advances only on handshake. The handshake at
//     rd_ptr=beats-1 goes to IDLE.
// - Latency: first result is valid the cycle after the last input handshake. REPLAY sustains
//   1 beat/cycle with out_ready_i=1.
// - done_o: high for the single cycle after the final output handshake, coincident with
//   state=IDLE.
// - Outputs outside RESULT/REPLAY: out_valid_o=0, out_data_o=0. Outside LOAD: in_ready_o=0.
// - Max compare is signed. Sum intermediates use a DATA_W+$clog2(LANES) lane adder; the
//   accumulator truncates to DATA_W.
// TESTING (bench: LANES=4, DATA_W=16, MAX_BEATS=4)
// 1. MAX, beats=2: [3,-7,12,0],[5,11,-2,9] -> one beat [12,0,0,0]; done_o pulses once.
// 2. SUM, beats=3, all lanes 1 -> [12,0,0,0]. SUM, beats=1: [0x7FFF,1,0,0] -> lane0 = 0x8000
//    (wrap).
// 3. SUB_MAX, beats=2, data as test 1, out_ready_i toggling 1,0,0,1 -> [-9,-19,0,-12] then
//    [-7,-1,-14,-3]; out_data_o stable during stalls.
// 4. MAX, all-negative row [-5,-3,-8,-4], in_valid_i gapped -> [-3,0,0,0]; busy_o high
//    throughout.
// 5. start_i with beats=0, beats=5, or mode=3 -> err_o 1-cycle pulse; busy_o stays 0;
//    in_ready_o stays 0.
// 6. rst_ni low mid-REPLAY -> out_valid_o=0 and busy_o=0 immediately. A following MAX op
//    gives the correct result; a start_i pulsed while busy is ignored.

Source files
------------

// File: rtl/sfu_row_reduce.sv
// Streaming row reduction: row max, row sum, or the row replayed minus its max.
// The row is read once; a beat buffer feeds the replay with full output backpressure.
module sfu_row_reduce #(
    parameter int LANES     = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 32,
    parameter int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [1:0]                cfg_mode_i,
    input  logic [BEAT_W-1:0]         cfg_beats_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [LANES*DATA_W-1:0]   in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES*DATA_W-1:0]   out_data_o
);

    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int SUM_W = DATA_W + $clog2(LANES);
    localparam logic [BEAT_W-1:0] MAX_BEATS_B = BEAT_W'(MAX_BEATS);
    localparam logic [1:0] MODE_MAX = 2'd0;
    localparam logic [1:0] MODE_SUB = 2'd2;

    typedef enum logic [1:0] {IDLE, LOAD, RESULT, REPLAY} state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q;
    logic [BEAT_W-1:0]   beats_q, cnt_q, rd_ptr_q;
    logic [DATA_W-1:0]   max_acc_q, sum_acc_q;
    logic                done_q, err_q;
    logic [LANES*DATA_W-1:0] row_buf [MAX_BEATS];

    logic [DATA_W-1:0]   lane, beat_max;
    logic [SUM_W-1:0]    beat_sum;
    logic                cfg_ok, start_ok, in_hs, out_hs, last_in, last_out;
    logic [LANES*DATA_W-1:0] rd_data;
    logic                unused_sum_hi;

    assign cfg_ok   = (cfg_mode_i <= MODE_SUB) && (cfg_beats_i != '0) && (cfg_beats_i <= MAX_BEATS_B);
    assign start_ok = (state_q == IDLE) && start_i && cfg_ok;
    assign in_hs    = (state_q == LOAD) && in_valid_i;
    assign out_hs   = ((state_q == RESULT) || (state_q == REPLAY)) && out_ready_i;
    assign last_in  = (cnt_q + BEAT_W'(1)) == beats_q;
    assign last_out = (rd_ptr_q + BEAT_W'(1)) == beats_q;
    assign rd_data  = row_buf[rd_ptr_q[IDX_W-1:0]];
    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign err_o    = err_q;
    // The accumulator keeps only DATA_W bits of the widened lane sum.
    assign unused_sum_hi = ^beat_sum[SUM_W-1:DATA_W];

    always_comb begin
        lane     = '0;
        beat_max = in_data_i[DATA_W-1:0];
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane = in_data_i[k*DATA_W +: DATA_W];
            if ($signed(lane) > $signed(beat_max)) beat_max = lane;
            beat_sum = beat_sum + SUM_W'($signed(lane));
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        case (state_q)
            IDLE: if (start_ok) state_d = LOAD;
            LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i && last_in) state_d = (mode_q == MODE_SUB) ? REPLAY : RESULT;
            end
            RESULT: begin
                out_valid_o = 1'b1;
                out_data_o[DATA_W-1:0] = (mode_q == MODE_MAX) ? max_acc_q : sum_acc_q;
                if (out_ready_i) state_d = IDLE;
            end
            REPLAY: begin
                out_valid_o = 1'b1;
                for (int k = 0; k < LANES; k++)
                    out_data_o[k*DATA_W +: DATA_W] = rd_data[k*DATA_W +: DATA_W] - max_acc_q;
                if (out_ready_i && last_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q    <= '0;
            beats_q   <= '0;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            max_acc_q <= '0;
            sum_acc_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= out_hs && ((state_q == RESULT) || last_out);
            err_q  <= (state_q == IDLE) && start_i && !cfg_ok;
            if (start_ok) begin
                mode_q    <= cfg_mode_i;
                beats_q   <= cfg_beats_i;
                cnt_q     <= '0;
                rd_ptr_q  <= '0;
                max_acc_q <= {1'b1, {(DATA_W-1){1'b0}}};
                sum_acc_q <= '0;
            end
            if (in_hs) begin
                cnt_q     <= cnt_q + BEAT_W'(1);
                sum_acc_q <= sum_acc_q + beat_sum[DATA_W-1:0];
                if ($signed(beat_max) > $signed(max_acc_q)) max_acc_q <= beat_max;
            end
            if ((state_q == REPLAY) && out_ready_i) rd_ptr_q <= rd_ptr_q + BEAT_W'(1);
        end
    end

    // Row storage is deliberately unreset; only SUB_MAX ever reads it back.
    always_ff @(posedge clk_i) begin
        if (in_hs && (mode_q == MODE_SUB)) row_buf[cnt_q[IDX_W-1:0]] <= in_data_i;
    end

endmodule

// File: tb/tb_sfu_row_reduce.sv
// Self-checking bench for sfu_row_reduce: directed cases plus randomized rows
// checked against a plain-arithmetic row model.
module tb_sfu_row_reduce;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int MB    = 4;
    localparam int BW    = $clog2(MB + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        cfg_mode = '0;
    logic [BW-1:0]     cfg_beats = '0;
    logic              start = 1'b0;
    logic              busy, done, err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [LANES*DW-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LANES*DW-1:0] out_data;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] rowData [MB][LANES];
    logic [DW-1:0] expData [MB][LANES];
    int            expBeats;

    sfu_row_reduce #(.LANES(LANES), .DATA_W(DW), .MAX_BEATS(MB), .BEAT_W(BW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_mode_i(cfg_mode), .cfg_beats_i(cfg_beats), .start_i(start),
        .busy_o(busy), .done_o(done), .err_o(err),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reportTimeout(input string tag);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out waiting for handshake", tag);
    endtask

    // Reference model: row max, row sum, or each element minus the row max, all mod 2^16.
    task automatic buildExpected(input int mode, input int beats);
        int m, s, v;
        m = -32768;
        s = 0;
        for (int b = 0; b < MB; b++)
            for (int k = 0; k < LANES; k++) expData[b][k] = '0;
        for (int b = 0; b < beats; b++)
            for (int k = 0; k < LANES; k++) begin
                v = int'($signed(rowData[b][k]));
                if (v > m) m = v;
                s = s + v;
            end
        if (mode == 0) begin
            expData[0][0] = 16'(m);
            expBeats = 1;
        end else if (mode == 1) begin
            expData[0][0] = 16'(s);
            expBeats = 1;
        end else begin
            for (int b = 0; b < beats; b++)
                for (int k = 0; k < LANES; k++)
                    expData[b][k] = 16'(int'($signed(rowData[b][k])) - m);
            expBeats = beats;
        end
    endtask

    function automatic logic [LANES*DW-1:0] packRow(input int b);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*DW +: DW] = rowData[b][k];
        return r;
    endfunction

    function automatic logic [LANES*DW-1:0] packExp(input int b);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*DW +: DW] = expData[b][k];
        return r;
    endfunction

    task automatic setRow(input int b, input int l0, input int l1, input int l2, input int l3);
        rowData[b][0] = 16'(l0);
        rowData[b][1] = 16'(l1);
        rowData[b][2] = 16'(l2);
        rowData[b][3] = 16'(l3);
    endtask

    task automatic loadRow(input int mode, input int beats, input int gapPct, input bit pokeStart);
        int waitCnt;
        bit taken;
        buildExpected(mode, beats);
        cfg_mode  = 2'(mode);
        cfg_beats = BW'(beats);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < beats; b++) begin
            while ($urandom_range(99) < gapPct) begin
                in_valid = 1'b0;
                @(negedge clk);
                checkOutput("busy_gap", busy, 1);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = packRow(b);
            if (pokeStart && b == 0) begin
                start = 1'b1;
                cfg_mode = 2'd1;
                cfg_beats = BW'(1);
            end
            waitCnt = 0;
            taken = 1'b0;
            while (!taken && waitCnt < 20) begin
                @(negedge clk);
                taken = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                waitCnt++;
            end
            if (!taken) reportTimeout("in_handshake");
        end
        in_valid = 1'b0;
    endtask

    task automatic consumeRow(input logic [7:0] rdyPat);
        int ob, cyc;
        bit accepted;
        ob = 0;
        cyc = 0;
        while (ob < expBeats && cyc < 100) begin
            out_ready = rdyPat[cyc % 8];
            cyc++;
            @(negedge clk);
            checkOutput("out_valid", out_valid, 1);
            checkOutput("out_data", out_data, packExp(ob));
            checkOutput("done_early", done, 0);
            accepted = out_ready && out_valid;
            @(posedge clk); #1;
            if (accepted) ob++;
        end
        out_ready = 1'b0;
        if (ob < expBeats) reportTimeout("out_handshake");
        @(negedge clk);
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_after", busy, 0);
        checkOutput("valid_after", out_valid, 0);
        checkOutput("data_after", out_data, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("done_single", done, 0);
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int mode, input int beats, input int gapPct, input logic [7:0] rdyPat);
        loadRow(mode, beats, gapPct, 1'b0);
        consumeRow(rdyPat);
    endtask

    task automatic checkReject(input int mode, input int beats);
        cfg_mode  = 2'(mode);
        cfg_beats = BW'(beats);
        start = 1'b1;
        @(negedge clk);
        checkOutput("rej_ready_pre", in_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("rej_err", err, 1);
        checkOutput("rej_busy", busy, 0);
        checkOutput("rej_ready", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rej_err_single", err, 0);
        checkOutput("rej_busy2", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        setRow(0, 3, -7, 12, 0);
        setRow(1, 5, 11, -2, 9);
        applyStimulus(0, 2, 0, 8'hFF);

        for (int b = 0; b < 3; b++) setRow(b, 1, 1, 1, 1);
        applyStimulus(1, 3, 0, 8'hFF);
        setRow(0, 16'h7FFF, 1, 0, 0);
        applyStimulus(1, 1, 0, 8'hFF);

        setRow(0, 3, -7, 12, 0);
        setRow(1, 5, 11, -2, 9);
        applyStimulus(2, 2, 0, 8'b1001_1001);

        setRow(0, -5, -3, -8, -4);
        applyStimulus(0, 1, 60, 8'hFF);

        checkReject(0, 0);
        checkReject(0, 5);
        checkReject(3, 2);

        setRow(0, 100, -50, 7, 8);
        setRow(1, 1, 2, 3, 4);
        setRow(2, -1, -2, -3, 30000);
        loadRow(2, 3, 0, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("replay_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        setRow(0, -20, 40, 39, -1);
        setRow(1, 41, 0, -32768, 2);
        loadRow(0, 2, 20, 1'b1);
        consumeRow(8'hFF);

        for (int t = 0; t < 12; t++) begin
            int mode, beats;
            mode  = int'($urandom_range(2));
            beats = int'($urandom_range(MB, 1));
            for (int b = 0; b < MB; b++)
                for (int k = 0; k < LANES; k++) rowData[b][k] = 16'($urandom);
            applyStimulus(mode, beats, 30, 8'($urandom) | 8'h01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
